exec_result_stage: RTL
======================

Name: exec_result_stage

Overview:
- Execute-stage output stage, directly downstream of the shift unit and the ALU.
- Selects one result per instruction from ALU output, shift output, immediate pass-through or link value (pc + 1).
- Derives zero/negative flags from the selected value and registers the result, destination register and write-enable toward the memory/writeback stage.
- Includes a 2-entry skid buffer with valid/ready handshake so downstream stalls never drop a result.

Parameters:
- DATA_W, 32, datapath width of all result/operand buses.
- RADDR_W, 4, destination register index width.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all buffered entries.
- in_valid  input  1  upstream presents an instruction result.
- in_ready  output  1  stage can accept this cycle.
- res_sel  input  2  result source: 00 ALU, 01 shift, 10 imm, 11 pc+1.
- alu_out  input  DATA_W  ALU result.
- shift_out  input  DATA_W  shift unit result.
- imm  input  DATA_W  immediate pass-through.
- pc  input  DATA_W  instruction PC for link value.
- rd_in  input  RADDR_W  destination register.
- we_in  input  1  register write-enable.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  selected result.
- out_rd  output  RADDR_W  destination register.
- out_we  output  1  write-enable.
- out_zero  output  1  out_data == 0.
- out_neg  output  1  out_data[DATA_W-1].

Behaviour:
- Reset (async, rst=1): all outputs and internal entries 0; out_valid=0; in_ready=1 on the first cycle after release.
- Select:
  - sel_data = mux(res_sel).
  - pc+1 is modulo 2^DATA_W; all-ones wraps to 0 and sets zero=1.
  - zero and neg are computed from sel_data at accept time and stored with the entry.
- Accept: in_valid && in_ready at a clock edge.
- Storage: main entry (drives outputs) and skid entry. in_ready = !skid_valid, a registered term with no combinational path from out_ready.
- Latency: an accepted result appears on out_* the next cycle when main is empty or draining.
- Per-edge rules, with out_fire = out_valid && out_ready:
  - main empty: accept loads main.
  - main full, out_fire, skid empty: accept loads main; else main empties.
  - main full, !out_fire: accept loads skid; in_ready drops next cycle.
  - out_fire with skid full: skid moves to main, skid empties; in_ready rises next cycle.
- Ordering: strict FIFO; no entry is ever duplicated or lost.
- Output stability: out_* hold stable while out_valid && !out_ready.
- flush=1: main_valid and skid_valid cleared next edge. Flush wins over a simultaneous accept and a simultaneous out_fire. Data fields may retain stale values; out_we is forced 0 whenever out_valid=0.
- Reset mid-operation: entries discarded immediately, with no partial transfer.
- Undefined res_sel: none; all 4 codes are defined.

Optional Feature:
- Macro: EXEC_FLAGS_REG_EN.
- Defined:
  - Adds outputs flag_z and flag_n, each 1 bit, from a persistent flags register (reset 0).
  - The register loads out_zero/out_neg on each out_fire whose entry has res_sel 00 or 01 (ALU/shift only). Each entry stores a 1-bit is_arith tag for this.
  - flush does not alter the flags register.
- Undefined: no flag_z/flag_n ports, no flags register, no is_arith tag.

Decomposition:
- Shared package holds:
  - res_sel encodings: RES_ALU=2'b00, RES_SHIFT=2'b01, RES_IMM=2'b10, RES_LINK=2'b11.
  - DATA_W / RADDR_W defaults.
  - An entry struct/bundle: data, rd, we, zero, neg, optional is_arith.
- One natural sub-module, exec_skid_buf: generic 2-entry valid/ready skid buffer, parameterised on payload width. The top holds the select/flag logic plus the optional flags register.

Test Plan:
- Basic select:
  - res_sel=01, shift_out=32'h0000_0F00, rd_in=5, we_in=1, out_ready=1 → next cycle out_valid=1, out_data=32'h0000_0F00, out_rd=5, out_zero=0, out_neg=0.
  - res_sel=11, pc=32'hFFFF_FFFF → out_data=0, out_zero=1.
- Negative flag: res_sel=00, alu_out=32'h8000_0000 → out_neg=1, out_zero=0.
- Backpressure:
  - out_ready=0 while issuing A=1, B=2 on consecutive cycles → after B, in_ready=0 and out_data=1 held.
  - Raise out_ready → outputs 1 then 2 on consecutive cycles; in_ready returns to 1.
- Flush:
  - With main and skid full, assert flush together with in_valid (C=3) → next cycle out_valid=0, out_we=0, in_ready=1.
  - C is not delivered.
- Async reset: assert rst mid-cycle with both entries full → out_valid and out_data go 0 immediately, without waiting for a clock edge.
- Flags register (EXEC_FLAGS_REG_EN):
  - ALU result 0 fires → flag_z=1.
  - Then imm=0 fires → flag_z stays 1.
  - Then shift result 32'hF000_0000 fires → flag_z=0, flag_n=1.

Source files
------------

// File: rtl/exec_result_stage_pkg.sv
// Shared encodings and entry layout for the execute result stage.
// EXEC_FLAGS_REG_EN adds the is_arith tag to each entry.
package exec_result_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        RES_ALU   = 2'b00,
        RES_SHIFT = 2'b01,
        RES_IMM   = 2'b10,
        RES_LINK  = 2'b11
    } res_sel_t;

    // Entry layout at the default widths.
    typedef struct packed {
        logic [DATA_W_DEF-1:0]  data;
        logic [RADDR_W_DEF-1:0] rd;
        logic                   we;
        logic                   zero;
        logic                   neg;
`ifdef EXEC_FLAGS_REG_EN
        logic                   is_arith;
`endif
    } entry_t;

    function automatic logic is_arith_sel(input logic [1:0] sel);
        return (sel == RES_ALU) || (sel == RES_SHIFT);
    endfunction

endpackage

// File: rtl/exec_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: 1-cycle latency, in_ready is registered
// (!skid_valid) so there is no combinational path from out_ready; flush clears both entries.
module exec_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         out_fire;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid && in_ready;
    assign out_fire  = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid) begin
            // skid is always empty while main is empty
            if (accept) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end
        end else if (out_fire) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/exec_result_stage.sv
// Execute result select + zero/neg flags into a skid buffer: 1-cycle latency, stalls held without loss.
// EXEC_FLAGS_REG_EN adds a persistent flag_z/flag_n register fed by fired ALU/shift results.
module exec_result_stage
    import exec_result_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         res_sel,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  shift_out,
    input  logic [DATA_W-1:0]  imm,
    input  logic [DATA_W-1:0]  pc,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               we_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_we,
    output logic               out_zero,
    output logic               out_neg
`ifdef EXEC_FLAGS_REG_EN
    ,
    output logic               flag_z,
    output logic               flag_n
`endif
);

    // Same field order as entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               zero;
        logic               neg;
`ifdef EXEC_FLAGS_REG_EN
        logic               is_arith;
`endif
    } stage_entry_t;

    localparam int ENTRY_W = $bits(stage_entry_t);

    logic [DATA_W-1:0]  sel_data;
    stage_entry_t       in_entry;
    stage_entry_t       out_entry;
    logic [ENTRY_W-1:0] buf_out;

    always_comb begin
        sel_data = alu_out;
        case (res_sel)
            RES_ALU:   sel_data = alu_out;
            RES_SHIFT: sel_data = shift_out;
            RES_IMM:   sel_data = imm;
            RES_LINK:  sel_data = pc + DATA_W'(1);
            default:   sel_data = alu_out;
        endcase
    end

    always_comb begin
        in_entry      = '0;
        in_entry.data = sel_data;
        in_entry.rd   = rd_in;
        in_entry.we   = we_in;
        in_entry.zero = (sel_data == '0);
        in_entry.neg  = sel_data[DATA_W-1];
`ifdef EXEC_FLAGS_REG_EN
        in_entry.is_arith = is_arith_sel(res_sel);
`endif
    end

    exec_skid_buf #(
        .W(ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (buf_out)
    );

    assign out_entry = stage_entry_t'(buf_out);
    assign out_data  = out_entry.data;
    assign out_rd    = out_entry.rd;
    assign out_we    = out_valid && out_entry.we;
    assign out_zero  = out_entry.zero;
    assign out_neg   = out_entry.neg;

`ifdef EXEC_FLAGS_REG_EN
    // A flushed entry is squashed, so it never updates the flags even if out_ready was high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (!flush && out_valid && out_ready && out_entry.is_arith) begin
            flag_z <= out_entry.zero;
            flag_n <= out_entry.neg;
        end
    end
`endif

endmodule
